// File: rtl/branch_resolver.sv
// Conditional branch resolver: holds the S/Z/C/V flag register, evaluates the
// branch condition with same-cycle flag bypass, and drives a registered redirect plus timed flush.
module branch_resolver #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  szcv_in,
  input  logic        flag_we,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_cond,
  input  logic [15:0] pc,
  input  logic [7:0]  disp,
  output logic [3:0]  flags,
  output logic        redirect_valid,
  output logic        taken,
  output logic [15:0] redirect_pc,
  output logic        flush
);

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;

  logic [3:0]  eff_flags;
  logic        s, z, c, v;
  logic        cond_met;
  logic        accept;
  logic [15:0] fall_pc;
  logic [15:0] target_pc;

  // A flag write in the same cycle as the branch is visible to that branch.
  always_comb begin
    eff_flags = flag_we ? szcv_in : flags;
    {s, z, c, v} = eff_flags;
    case (br_cond)
      3'b000:  cond_met = z;
      3'b001:  cond_met = s ^ v;
      3'b010:  cond_met = z | (s ^ v);
      3'b011:  cond_met = ~z;
      3'b100:  cond_met = 1'b1;
      3'b101:  cond_met = c;
      default: cond_met = 1'b0;
    endcase
  end

  assign br_ready  = (state_q == StIdle);
  assign flush     = (state_q == StFlush);
  assign accept    = br_valid && br_ready;
  assign fall_pc   = pc + 16'd1;
  assign target_pc = fall_pc + {{8{disp[7]}}, disp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (flag_we) begin
      flags <= szcv_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      redirect_valid <= 1'b0;
      taken          <= 1'b0;
      redirect_pc    <= 16'h0000;
    end else begin
      redirect_valid <= accept;
      taken          <= accept && cond_met;
      redirect_pc    <= accept ? (cond_met ? target_pc : fall_pc) : 16'h0000;
      unique case (state_q)
        StIdle: begin
          if (accept && cond_met) begin
            state_q <= StFlush;
            cnt_q   <= FlushLoad;
          end
        end
        StFlush: begin
          if (cnt_q == 4'd0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a per-cycle model comparison plus hand-computed
// literal checks, including a FLUSH_CYCLES=1 instance for the reset-mid-flush case.
module tb_branch_resolver;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  szcv_in = 4'b0000;
  logic        flag_we = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_cond = 3'b000;
  logic [15:0] pc = 16'h0000;
  logic [7:0]  disp = 8'h00;

  logic        br_ready, redirect_valid, taken, flush;
  logic [3:0]  flags;
  logic [15:0] redirect_pc;
  logic        br_ready1, redirect_valid1, taken1, flush1;
  logic [3:0]  flags1;
  logic [15:0] redirect_pc1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolver #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .szcv_in(szcv_in), .flag_we(flag_we), .br_valid(br_valid),
    .br_ready(br_ready), .br_cond(br_cond), .pc(pc), .disp(disp), .flags(flags),
    .redirect_valid(redirect_valid), .taken(taken), .redirect_pc(redirect_pc), .flush(flush)
  );

  branch_resolver #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .szcv_in(szcv_in), .flag_we(flag_we), .br_valid(br_valid),
    .br_ready(br_ready1), .br_cond(br_cond), .pc(pc), .disp(disp), .flags(flags1),
    .redirect_valid(redirect_valid1), .taken(taken1), .redirect_pc(redirect_pc1),
    .flush(flush1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flag state, remaining flush cycles, last resolution.
  logic [3:0]  m_flags = 4'b0000;
  int          m_busy = 0;
  logic        m_rv = 1'b0;
  logic        m_tk = 1'b0;
  logic [15:0] m_pc = 16'h0000;

  function automatic logic cond_met(input logic [3:0] f, input logic [2:0] cc);
    logic s, z, c, v;
    {s, z, c, v} = f;
    case (cc)
      3'd0: return z;
      3'd1: return s != v;
      3'd2: return z || (s != v);
      3'd3: return !z;
      3'd4: return 1'b1;
      3'd5: return c;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flags = 4'b0000;
      m_busy  = 0;
      m_rv    = 1'b0;
      m_tk    = 1'b0;
      m_pc    = 16'h0000;
    end else begin
      logic [3:0] eff;
      logic       acc;
      int         t;
      eff  = flag_we ? szcv_in : m_flags;
      acc  = br_valid && (m_busy == 0);
      m_rv = acc;
      m_tk = acc && cond_met(eff, br_cond);
      t    = int'(pc) + 1 + (m_tk ? int'($signed(disp)) : 0);
      m_pc = acc ? 16'(t) : 16'h0000;
      if (m_busy > 0) m_busy = m_busy - 1;
      else if (m_tk) m_busy = FC;
      if (flag_we) m_flags = szcv_in;
    end
  end

  always @(negedge clk) begin
    chk("br_ready", 16'(br_ready), 16'(m_busy == 0));
    chk("flush", 16'(flush), 16'(m_busy > 0));
    chk("flags", 16'(flags), 16'(m_flags));
    chk("redirect_valid", 16'(redirect_valid), 16'(m_rv));
    if (m_rv || rst) begin
      chk("taken", 16'(taken), 16'(m_tk));
      chk("redirect_pc", redirect_pc, m_pc);
    end
  end

  task automatic issue(input logic [2:0] cc, input logic [15:0] p, input logic [7:0] d);
    br_valid = 1'b1;
    br_cond  = cc;
    pc       = p;
    disp     = d;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    idle_cycles(2);
    chk("reset_ready_lit", 16'(br_ready), 16'd1);
    chk("reset_flags_lit", 16'(flags), 16'd0);
    rst = 1'b0;

    // BE taken after Z set: target 0x10 + 1 + 5.
    flag_we = 1'b1; szcv_in = 4'b0100;
    @(negedge clk);
    flag_we = 1'b0;
    issue(3'b000, 16'h0010, 8'h05);
    @(negedge clk);
    br_valid = 1'b0;
    chk("be_rv_lit", 16'(redirect_valid), 16'd1);
    chk("be_taken_lit", 16'(taken), 16'd1);
    chk("be_pc_lit", redirect_pc, 16'h0016);
    chk("be_flush_lit", 16'(flush), 16'd1);
    @(negedge clk);
    chk("be_flush2_lit", 16'(flush), 16'd1);
    chk("be_ready2_lit", 16'(br_ready), 16'd0);
    @(negedge clk);
    chk("be_flush_end_lit", 16'(flush), 16'd0);
    chk("be_ready_end_lit", 16'(br_ready), 16'd1);

    // BLT with S=1,V=0 taken backwards; then S=1,V=1 not taken.
    flag_we = 1'b1; szcv_in = 4'b1000;
    @(negedge clk);
    flag_we = 1'b0;
    issue(3'b001, 16'h0100, 8'hFE);
    @(negedge clk);
    br_valid = 1'b0;
    chk("blt_taken_lit", 16'(taken), 16'd1);
    chk("blt_pc_lit", redirect_pc, 16'h00FF);
    idle_cycles(2);
    flag_we = 1'b1; szcv_in = 4'b1001;
    @(negedge clk);
    flag_we = 1'b0;
    issue(3'b001, 16'h0100, 8'hFE);
    @(negedge clk);
    br_valid = 1'b0;
    chk("blt_nt_lit", 16'(taken), 16'd0);
    chk("blt_nt_pc_lit", redirect_pc, 16'h0101);
    chk("blt_nt_flush_lit", 16'(flush), 16'd0);

    // Register Z=0, then BNE with a same-cycle write of Z=1 must use the bypass.
    flag_we = 1'b1; szcv_in = 4'b0000;
    @(negedge clk);
    szcv_in = 4'b0100;
    issue(3'b011, 16'h0200, 8'h03);
    @(negedge clk);
    flag_we = 1'b0; br_valid = 1'b0;
    chk("bne_bypass_lit", 16'(taken), 16'd0);
    chk("bne_pc_lit", redirect_pc, 16'h0201);
    chk("bne_flags_lit", 16'(flags), 16'h0004);

    // Wrapping B, then a branch held during the flush is accepted exactly once.
    issue(3'b100, 16'hFFFF, 8'h00);
    @(negedge clk);
    chk("wrap_pc_lit", redirect_pc, 16'h0000);
    chk("wrap_taken_lit", 16'(taken), 16'd1);
    issue(3'b000, 16'h0300, 8'h10);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (redirect_valid) begin
        pulses++;
        br_valid = 1'b0;
        chk("held_pc_lit", redirect_pc, 16'h0311);
      end
    end
    br_valid = 1'b0;
    chk("held_pulses_lit", 16'(pulses), 16'd1);

    // Reset during the FLUSH_CYCLES=1 flush cycle.
    issue(3'b100, 16'h0040, 8'h00);
    @(negedge clk);
    br_valid = 1'b0;
    chk("f1_flush_lit", 16'(flush1), 16'd1);
    chk("f1_pc_lit", redirect_pc1, 16'h0041);
    #2 rst = 1'b1;
    #1;
    chk("f1_rst_flush_lit", 16'(flush1), 16'd0);
    chk("f1_rst_rv_lit", 16'(redirect_valid1), 16'd0);
    chk("f1_rst_taken_lit", 16'(taken1), 16'd0);
    chk("f1_rst_pc_lit", redirect_pc1, 16'h0000);
    chk("f1_rst_flags_lit", 16'(flags1), 16'd0);
    chk("rst_flush_lit", 16'(flush), 16'd0);
    idle_cycles(2);
    rst = 1'b0;
    @(negedge clk);
    chk("f1_post_ready_lit", 16'(br_ready1), 16'd1);
    chk("f1_post_flush_lit", 16'(flush1), 16'd0);
    chk("f1_post_flags_lit", 16'(flags1), 16'd0);

    // Reserved conditions with all flags set, back-to-back.
    flag_we = 1'b1; szcv_in = 4'b1111;
    @(negedge clk);
    flag_we = 1'b0;
    issue(3'b110, 16'h0500, 8'h07);
    @(negedge clk);
    issue(3'b111, 16'h0600, 8'h07);
    chk("rsv6_rv_lit", 16'(redirect_valid), 16'd1);
    chk("rsv6_taken_lit", 16'(taken), 16'd0);
    chk("rsv6_pc_lit", redirect_pc, 16'h0501);
    @(negedge clk);
    issue(3'b101, 16'h0700, 8'h80);
    chk("rsv7_rv_lit", 16'(redirect_valid), 16'd1);
    chk("rsv7_taken_lit", 16'(taken), 16'd0);
    chk("rsv7_pc_lit", redirect_pc, 16'h0601);
    @(negedge clk);
    br_valid = 1'b0;
    chk("bc_pc_lit", redirect_pc, 16'h0681);
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolves conditional branches against the S/Z/C/V flags produced by the 16-bit ALU. It holds the architectural flag register written from the ALU's `szcv` output and evaluates the branch condition, forwarding same-cycle flag writes. It computes the redirect PC, then drives a registered redirect plus a timed pipeline flush. It sits between the execute stage (flag producer) and the fetch/PC logic (redirect consumer).

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles `flush` stays high after a taken branch; legal range 1..15.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `szcv_in`, in, 4: flags from the ALU, ordered [3]=S, [2]=Z, [1]=C, [0]=V.
- `flag_we`, in, 1: write `szcv_in` into the flag register.
- `br_valid`, in, 1: branch request present.
- `br_ready`, out, 1: block can accept a branch; equals (state == IDLE).
- `br_cond`, in, 3: condition code.
- `pc`, in, 16: address of the branch instruction.
- `disp`, in, 8: signed displacement.
- `flags`, out, 4: current flag register.
- `redirect_valid`, out, 1: one-cycle pulse carrying the resolution.
- `taken`, out, 1: resolution outcome; meaningful only while `redirect_valid` is high.
- `redirect_pc`, out, 16: next PC; meaningful only while `redirect_valid` is high.
- `flush`, out, 1: squash younger instructions.

## Operation
- **Flag register:** loads `szcv_in` on every edge with `flag_we`=1, in any state.
- **Effective flags:** `szcv_in` when `flag_we`=1 in the same cycle (bypass), otherwise `flags`.
- **Condition codes** (S, Z, C, V are the effective flags):
  - 000 BE: Z
  - 001 BLT: S^V
  - 010 BLE: Z|(S^V)
  - 011 BNE: !Z
  - 100 B: 1
  - 101 BC: C
  - 110, 111: reserved; never taken.
- **Target:** pc + 1 + sign_extend16(disp), truncated to 16 bits (wraps; 0xFFFF + 1 + 0 = 0x0000).
- **Fall-through:** pc + 1, also mod 2^16.
- **Accept:** a branch is accepted on an edge where `br_valid` && `br_ready`. `br_valid` while `br_ready`=0 is ignored; the requester must hold it.
- **State machine:**
  - IDLE → FLUSH on accepting a taken branch; the counter loads FLUSH_CYCLES-1.
  - IDLE → IDLE on a not-taken branch or with no request.
  - FLUSH: the counter decrements each edge. At 0 the state returns to IDLE on the next edge.
- **Outputs:**
  - `flush` = (state == FLUSH).
  - `redirect_valid`, `taken` and `redirect_pc` are registered and written on every edge. `redirect_valid` is 0 unless a branch was accepted on that edge.
- **Reset (asynchronous):**
  - `flags`=0, state IDLE, counter 0.
  - `redirect_valid`=0, `taken`=0, `redirect_pc`=0, `flush`=0, `br_ready`=1 once `rst` deasserts.
- **Reset mid-flush:** reset aborts the flush immediately; no residual `flush` cycles afterwards.

## Timing
- **Latency:** 1 cycle. A branch accepted at edge N gives `redirect_valid`, `taken` and `redirect_pc` high/valid during cycle N→N+1 only.
- **Taken branch:** `flush` rises in the same cycle as `redirect_valid` and stays high for exactly FLUSH_CYCLES cycles. `br_ready` is low for those same cycles, then high.
- **Not-taken branch:** no `flush`; `br_ready` stays high, so back-to-back branches are accepted on consecutive edges.
- **Same-cycle flag write:** `flag_we` with `br_valid` in the same cycle makes the branch see the new flags, and the flag register also updates at that edge.
- **Inputs:** `br_cond`, `pc` and `disp` are sampled only at the accept edge.

## Test plan
- Reset, then `flag_we`=1, `szcv_in`=0100; next cycle BE with pc=0x0010, disp=0x05 → `redirect_valid`=1, `taken`=1, `redirect_pc`=0x0016, `flush` high 2 cycles, `br_ready` low 2 cycles.
- Flags S=1, V=0; BLT with pc=0x0100, disp=0xFE → taken, `redirect_pc`=0x00FF. Repeat with S=1, V=1 → not taken, `redirect_pc`=0x0101, no `flush`.
- Register Z=0, then `flag_we`=1 with `szcv_in`=0100 in the same cycle as BNE → not taken (bypass used); `flags` reads 0100 afterwards.
- Taken B at pc=0xFFFF, disp=0x00 → `redirect_pc`=0x0000. During the flush, hold `br_valid`=1 with another branch → no accept until `br_ready` returns, then exactly one `redirect_valid` pulse.
- With FLUSH_CYCLES=1, issue a taken B, then assert `rst` during the flush cycle → all outputs 0 at once; after release `br_ready`=1, `flush`=0, `flags`=0000.
- Conditions 110/111 with flags 1111 → `taken`=0, `redirect_pc`=pc+1. Back-to-back not-taken branches on consecutive edges → `redirect_valid` high on consecutive cycles.
